// File: rtl/passcode_keypad.sv
// passcode_keypad: debounced digit-entry front end for the passcode checker.
// Define KEYPAD_TIMEOUT_EN to abort attempts that stall longer than TIMEOUT_CYCLES.
module passcode_keypad #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CODE_LEN        = 3,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn,
    input  logic [3:0] sw,
    input  logic       rearm,
    output logic [3:0] din,
    output logic       digit_valid,
    output logic [2:0] digit_count,
    output logic       code_done,
    output logic       entry_abort,
    output logic [1:0] entry_state
);
    typedef enum logic [1:0] {IDLE = 2'b00, COLLECT = 2'b01, DONE = 2'b10} state_t;

    state_t      state, state_n;
    logic        s1, s2, deb, deb_q, press;
    logic [15:0] cnt;
    logic [3:0]  din_n;
    logic [2:0]  count_n;
    logic        valid_n, done_n;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            deb   <= 1'b0;
            deb_q <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            deb_q <= deb;
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
                deb <= ~deb;
                cnt <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    // Only the rising edge of the debounced level is a key event.
    assign press       = deb & ~deb_q;
    assign entry_state = state;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer, timer_n;
    logic          abort_n;
`endif

    always_comb begin
        state_n = state;
        din_n   = din;
        valid_n = 1'b0;
        count_n = digit_count;
        done_n  = 1'b0;
`ifdef KEYPAD_TIMEOUT_EN
        abort_n = 1'b0;
        timer_n = (state == COLLECT) ? timer + TW'(1) : '0;
`endif
        if (state == DONE) begin
            count_n = rearm ? 3'd0 : digit_count;
            state_n = rearm ? IDLE : DONE;
        end else if (press) begin
            din_n   = sw;
            valid_n = 1'b1;
            count_n = digit_count + 3'd1;
            done_n  = (count_n == 3'(CODE_LEN));
            state_n = done_n ? DONE : COLLECT;
`ifdef KEYPAD_TIMEOUT_EN
            timer_n = '0;
`endif
        end
`ifdef KEYPAD_TIMEOUT_EN
        // A press on the expiry cycle is handled above and therefore wins.
        else if (state == COLLECT && timer == TW'(TIMEOUT_CYCLES - 1)) begin
            abort_n = 1'b1;
            count_n = 3'd0;
            state_n = IDLE;
            timer_n = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            din         <= '0;
            digit_valid <= 1'b0;
            digit_count <= '0;
            code_done   <= 1'b0;
        end else begin
            state       <= state_n;
            din         <= din_n;
            digit_valid <= valid_n;
            digit_count <= count_n;
            code_done   <= done_n;
        end
    end

`ifdef KEYPAD_TIMEOUT_EN
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            timer       <= '0;
            entry_abort <= 1'b0;
        end else begin
            timer       <= timer_n;
            entry_abort <= abort_n;
        end
    end
`else
    assign entry_abort = 1'b0;
`endif
endmodule

// File: tb/tb_passcode_keypad.sv
// tb_passcode_keypad: table-driven presses plus hand sequences, checked by a strobe scoreboard.
module tb_passcode_keypad;
    localparam int D = 16;
    localparam int T = 50;

    logic       clk = 1'b0;
    logic       clr, btn, rearm;
    logic [3:0] sw;
    logic [3:0] din;
    logic       digit_valid, code_done, entry_abort;
    logic [2:0] digit_count;
    logic [1:0] entry_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int aborts = 0;
    int last_abort_cyc = 0;

    typedef struct {
        logic [3:0] din;
        logic [2:0] cnt;
        logic       done;
        int         cyc;
    } ev_t;
    ev_t sbq[$];

    typedef struct {
        logic [3:0] sw;
        bit         acc;
        logic [2:0] cnt;
        bit         done;
        logic [1:0] st;
        logic [3:0] din;
    } vec_t;
    vec_t tbl[3];

    passcode_keypad #(.DEBOUNCE_CYCLES(D), .CODE_LEN(3), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .clr(clr), .btn(btn), .sw(sw), .rearm(rearm),
        .din(din), .digit_valid(digit_valid), .digit_count(digit_count),
        .code_done(code_done), .entry_abort(entry_abort), .entry_state(entry_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk) begin
        if (!clr) begin
            if (digit_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    ev_t e;
                    e = sbq.pop_front();
                    chk("strobe_din", din, e.din);
                    chk("strobe_count", digit_count, e.cnt);
                    chk("strobe_done", code_done, e.done);
                    chk("strobe_cycle", cyc, e.cyc);
                end
            end
            if (code_done && !digit_valid) chk("done_without_valid", 32'd1, 32'd0);
            if (entry_abort) begin
                aborts++;
                last_abort_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) tick();
    endtask

    task automatic press_rise(input logic [3:0] s, input bit acc, input logic [2:0] cnt,
                              input bit done, output int e);
        ev_t x;
        sw = s;
        repeat (3) tick();
        e = cyc + D + 3;
        btn = 1'b1;
        if (acc) begin
            x.din = s;
            x.cnt = cnt;
            x.done = done;
            x.cyc = e;
            sbq.push_back(x);
        end
    endtask

    task automatic press_release(input int e);
        wait_until(e + 3);
        btn = 1'b0;
        wait_until(cyc + D + 6);
    endtask

    task automatic press(input logic [3:0] s, input bit acc, input logic [2:0] cnt,
                         input bit done, output int e);
        press_rise(s, acc, cnt, done, e);
        press_release(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_din"}, din, 4'h0);
        chk({tag, "_valid"}, digit_valid, 1'b0);
        chk({tag, "_count"}, digit_count, 3'd0);
        chk({tag, "_done"}, code_done, 1'b0);
        chk({tag, "_abort"}, entry_abort, 1'b0);
        chk({tag, "_state"}, entry_state, 2'b00);
    endtask

    initial begin
        int e, e2, e3, a0, n, c;
        ev_t x;
        clr = 1'b1; btn = 1'b0; sw = 4'h0; rearm = 1'b0;
        tbl[0] = '{4'hC, 1'b1, 3'd2, 1'b0, 2'b01, 4'hC};
        tbl[1] = '{4'hD, 1'b1, 3'd3, 1'b1, 2'b10, 4'hD};
        tbl[2] = '{4'h1, 1'b0, 3'd3, 1'b0, 2'b10, 4'hD};
        repeat (3) tick();
        check_reset_outputs("reset");
        clr = 1'b0;
        tick();

        // Bounce rejection: short pulses, then a stable rise.
        sw = 4'hC;
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            btn = 1'b1;
            repeat (5) tick();
            btn = 1'b0;
            repeat (5) tick();
        end
        c = cyc;
        btn = 1'b1;
        x.din = 4'hC; x.cnt = 3'd1; x.done = 1'b0; x.cyc = c + D + 3;
        sbq.push_back(x);
        wait_until(c + 40);
        btn = 1'b0;
        wait_until(cyc + D + 6);
        chk("bounce_count", digit_count, 3'd1);
        chk("bounce_state", entry_state, 2'b01);

        for (int i = 0; i < 3; i++) begin
            press(tbl[i].sw, tbl[i].acc, tbl[i].cnt, tbl[i].done, e);
            chk($sformatf("vec%0d_count", i), digit_count, tbl[i].cnt);
            chk($sformatf("vec%0d_state", i), entry_state, tbl[i].st);
            chk($sformatf("vec%0d_din", i), din, tbl[i].din);
        end

        // rearm in the same cycle as a press: press is dropped.
        press_rise(4'h5, 1'b0, 3'd0, 1'b0, e);
        wait_until(e - 1);
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        chk("rearm_state", entry_state, 2'b00);
        chk("rearm_count", digit_count, 3'd0);
        chk("rearm_din", din, 4'hD);
        press_release(e);

        press(4'h7, 1'b1, 3'd1, 1'b0, e);
        rearm = 1'b1;
        tick();
        rearm = 1'b0;
        tick();
        chk("rearm_collect_state", entry_state, 2'b01);
        chk("rearm_collect_count", digit_count, 3'd1);

`ifdef KEYPAD_TIMEOUT_EN
        a0 = aborts;
        n = 0;
        while (aborts == a0 && n < 200) begin
            tick();
            n++;
        end
        chk("abort_seen", aborts - a0, 1);
        chk("abort_cycle", last_abort_cyc, e + T);
        chk("abort_count", digit_count, 3'd0);
        chk("abort_state", entry_state, 2'b00);
        chk("abort_din", din, 4'h7);

        press_rise(4'h8, 1'b1, 3'd1, 1'b0, e2);
        wait_until(e2 + 3);
        btn = 1'b0;
        wait_until(e2 + T - 6 - D);
        a0 = aborts;
        press_rise(4'h9, 1'b1, 3'd2, 1'b0, e3);
        press_release(e3);
        wait_until(e3 + 30);
        chk("expiry_press_no_abort", aborts, a0);
        chk("expiry_press_count", digit_count, 3'd2);
        chk("expiry_press_state", entry_state, 2'b01);
`else
        wait_until(cyc + 10000);
        chk("no_timeout_aborts", aborts, 0);
        chk("no_timeout_state", entry_state, 2'b01);
        chk("no_timeout_count", digit_count, 3'd1);
        press(4'h6, 1'b1, 3'd2, 1'b0, e);
`endif

        chk("pre_reset_count", digit_count, 3'd2);
        chk("pre_reset_state", entry_state, 2'b01);
        @(negedge clk);
        #2 clr = 1'b1;
        #1 check_reset_outputs("async_reset");
        repeat (2) tick();
        clr = 1'b0;
        repeat (5) tick();
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/passcode_keypad.md
# passcode_keypad

Upstream entry stage for the passcode checker. Synchronizes and debounces a raw push-button, samples the 4-bit digit switches on each clean press, and presents one digit per press on `din` with a one-cycle `digit_valid` strobe. It counts digits per attempt, flags a completed code, and optionally aborts a stalled attempt, so the checker FSM only ever sees clean, single-cycle digit events.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive cycles the synchronized button must differ from the debounced level before that level flips; legal range 2..65535.
- `CODE_LEN`, 3: digits per attempt; legal range 1..7.
- `TIMEOUT_CYCLES`, 1000: inactivity limit inside an attempt; used only with `KEYPAD_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `clr`  in  1  asynchronous, active-high reset.
- `btn`  in  1  raw, bouncy, asynchronous digit-enter button; high = pressed.
- `sw`  in  4  digit switches; must be stable for at least 3 cycles before the press is accepted.
- `rearm`  in  1  synchronous one-cycle request to start a new attempt after `code_done`.
- `din`  out  4  last accepted digit; feeds the checker's digit input.
- `digit_valid`  out  1  one-cycle strobe, high in the cycle in which `din` holds a new digit.
- `digit_count`  out  3  digits accepted in the current attempt, 0..CODE_LEN.
- `code_done`  out  1  one-cycle strobe coincident with the `digit_valid` of the CODE_LEN-th digit.
- `entry_abort`  out  1  one-cycle strobe on timeout.
- `entry_state`  out  2  00 IDLE, 01 COLLECT, 10 DONE.

## Operation
- Reset (`clr` high, asynchronous): both sync flops, debounced level, debounce counter, timer, `din`, `digit_valid`, `digit_count`, `code_done` and `entry_abort` all go to 0, and `entry_state` goes to IDLE.
- Synchronizer: two flops on `btn`.
- Debounce: while the synchronized level is unequal to the debounced level, the counter increments. When it reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears. Any cycle with equal levels clears the counter.
- A press is a 0->1 transition of the debounced level. Releases produce no event.
- A button held through reset deasserts into a debounced level of 0, so it registers as a press after the full debounce time.
- On a press in IDLE or COLLECT:
  - `din` <= `sw`; `digit_valid` pulses; `digit_count` increments; the timer clears.
  - If the new count equals CODE_LEN, `code_done` pulses and the state goes to DONE. Otherwise the state goes to COLLECT.
- DONE:
  - Presses are ignored: no `digit_valid` and no change to `din`.
  - `rearm` clears `digit_count` and returns the state to IDLE.
  - If `rearm` and a press occur in the same cycle, `rearm` wins and the press is discarded.
- `rearm` has no effect in IDLE or COLLECT.
- `din` holds its value until the next accepted press. It is not cleared by `rearm` or by an abort.

## Timing
- `btn` rising, bounce-free, sampled at edge k: debounced level rises at edge k+1+DEBOUNCE_CYCLES. `din` and `digit_valid` are registered at edge k+2+DEBOUNCE_CYCLES.
- Total press-to-strobe latency is DEBOUNCE_CYCLES+2 cycles.
- `digit_valid`, `code_done` and `entry_abort` are each exactly one cycle wide and never back-to-back from a single press.
- Bounce pulses shorter than DEBOUNCE_CYCLES cycles produce no event.
- Minimum spacing between accepted presses is 2×DEBOUNCE_CYCLES cycles (press plus release).

## Configuration
- `KEYPAD_TIMEOUT_EN` defined:
  - In COLLECT, the timer counts cycles since the last accepted digit.
  - On reaching TIMEOUT_CYCLES, `entry_abort` pulses for one cycle, `digit_count` goes to 0 and the state goes to IDLE.
  - If a press lands in the same cycle as expiry, the press wins: it is accepted, the timer clears and there is no abort.
  - The timer is idle and held at 0 in IDLE and DONE.
- `KEYPAD_TIMEOUT_EN` undefined: no timer logic is generated, `entry_abort` is tied to 0, and an attempt waits indefinitely.

## Test plan
- Reset check: assert `clr` mid-COLLECT with `digit_count`=2 -> all outputs 0 and `entry_state`=IDLE within the same cycle, asynchronously.
- Bounce rejection: DEBOUNCE_CYCLES=16, `sw`=4'hC, `btn` toggling 5-cycle pulses, then held high 40 cycles -> exactly one `digit_valid` with `din`=4'hC, 18 cycles after the stable rise.
- Full code: presses with `sw`=C, C, D -> `digit_valid` ×3, `digit_count` 1,2,3, `code_done` coincident with the third strobe, `entry_state`=DONE.
- DONE behaviour:
  - A fourth press with `sw`=4'h1 -> no strobe, `din` stays 4'hD.
  - `rearm` together with a press -> IDLE, `digit_count`=0, press discarded.
- Timeout (macro on, TIMEOUT_CYCLES=50): one digit, then idle 50 cycles -> `entry_abort` pulse, `digit_count`=0, IDLE. A press on the expiry cycle -> accepted, no abort.
- Macro off: one digit, then idle 10000 cycles -> `entry_abort` stays 0, state stays COLLECT.
